// File: rtl/spm_banked.sv
// rtl/spm_banked.sv - banked dual-port scratchpad (IF/MEM) with same-bank arbitration and zero-fill
module spm_banked #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int NUM_BANKS  = 4,
  parameter int STARVE_MAX = 3,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_busy,
  input  logic [ADDR_W-1:0]   if_spm_addr,
  input  logic                if_spm_as_,
  input  logic                if_spm_rw,
  input  logic [DATA_W/8-1:0] if_spm_be,
  input  logic [DATA_W-1:0]   if_spm_wr_data,
  output logic [DATA_W-1:0]   if_spm_rd_data,
  output logic                if_spm_rdy_,
  input  logic [ADDR_W-1:0]   mem_spm_addr,
  input  logic                mem_spm_as_,
  input  logic                mem_spm_rw,
  input  logic [DATA_W/8-1:0] mem_spm_be,
  input  logic [DATA_W-1:0]   mem_spm_wr_data,
  output logic [DATA_W-1:0]   mem_spm_rd_data,
  output logic                mem_spm_rdy_
);
  localparam int BE_W     = DATA_W / 8;
  localparam int LOG_NB   = $clog2(NUM_BANKS);
  localparam int BANK_W   = (LOG_NB > 0) ? LOG_NB : 1;
  localparam int ROW_BITS = ADDR_W - LOG_NB;
  localparam int ROW_W    = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int ROWS     = (1 << ADDR_W) / NUM_BANKS;
  localparam int CNT_W    = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  init_row, init_row_nxt;
  logic [CNT_W-1:0]  starve_cnt;

  logic [BANK_W-1:0] if_bank, mem_bank;
  logic [ROW_W-1:0]  if_row, mem_row;
  logic              if_req, mem_req, conflict, if_wins, if_gnt, mem_gnt;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;

  assign if_bank  = BANK_W'(if_spm_addr & ADDR_W'(NUM_BANKS - 1));
  assign mem_bank = BANK_W'(mem_spm_addr & ADDR_W'(NUM_BANKS - 1));
  assign if_row   = ROW_W'(if_spm_addr >> LOG_NB);
  assign mem_row  = ROW_W'(mem_spm_addr >> LOG_NB);

  // Reset and zero-fill both mask requests; a masked request is simply dropped.
  assign if_req   = !reset && (state == ST_RUN) && !if_spm_as_;
  assign mem_req  = !reset && (state == ST_RUN) && !mem_spm_as_;
  assign conflict = if_req && mem_req && (if_bank == mem_bank);
  assign if_wins  = (STARVE_MAX > 0) && (starve_cnt == CNT_W'(STARVE_MAX));
  assign mem_gnt  = mem_req && !(conflict && if_wins);
  assign if_gnt   = if_req && !(conflict && !if_wins);

  assign if_spm_rdy_  = !if_gnt;
  assign mem_spm_rdy_ = !mem_gnt;
  assign init_busy    = reset ? (INIT_CLEAR != 0) : (state == ST_INIT);

  always_comb begin
    state_nxt    = state;
    init_row_nxt = init_row;
    if (state == ST_INIT) begin
      init_row_nxt = init_row + 1'b1;
      if (init_row == ROW_W'(ROWS - 1)) begin
        state_nxt    = ST_RUN;
        init_row_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      init_row <= '0;
    end else begin
      state    <= state_nxt;
      init_row <= init_row_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (conflict && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Each bank has one access port; at most one granted port maps onto it per cycle.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] ram [ROWS];
    logic              sel_mem, sel_if, we;
    logic [ROW_W-1:0]  row;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;

    always_comb begin
      sel_mem = mem_gnt && (mem_bank == BANK_W'(b));
      sel_if  = if_gnt && (if_bank == BANK_W'(b));
      we      = 1'b0;
      row     = init_row;
      be      = '0;
      wdata   = '0;
      if (state == ST_INIT) begin
        we = !reset;
        be = '1;
      end else if (sel_mem) begin
        row   = mem_row;
        we    = !mem_spm_rw;
        be    = mem_spm_be;
        wdata = mem_spm_wr_data;
      end else if (sel_if) begin
        row   = if_row;
        we    = !if_spm_rw;
        be    = if_spm_be;
        wdata = if_spm_wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) ram[row][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end

    assign bank_rdata[b] = ram[row];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_spm_rd_data  <= '0;
      mem_spm_rd_data <= '0;
    end else begin
      if (if_gnt && if_spm_rw)   if_spm_rd_data  <= bank_rdata[if_bank];
      if (mem_gnt && mem_spm_rw) mem_spm_rd_data <= bank_rdata[mem_bank];
    end
  end
endmodule

// File: tb/tb_spm_banked.sv
// tb/tb_spm_banked.sv - randomized self-checking bench for spm_banked against a word-array model
module tb_spm_banked;
  localparam int DW = 32, AW = 6, NB = 4, BEW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, reset_c;
  logic [AW-1:0] if_addr, mem_addr;
  logic if_as_, mem_as_, if_rw, mem_rw;
  logic [BEW-1:0] if_be, mem_be;
  logic [DW-1:0] if_wd, mem_wd;

  logic busy_a, if_rdy_a, mem_rdy_a, busy_b, if_rdy_b, mem_rdy_b, busy_c, if_rdy_c, mem_rdy_c;
  logic [DW-1:0] if_rd_a, mem_rd_a, if_rd_b, mem_rd_b, if_rd_c, mem_rd_c;

  spm_banked #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .STARVE_MAX(3), .INIT_CLEAR(1)) dut_a (
    .clk(clk), .reset(reset_a), .init_busy(busy_a),
    .if_spm_addr(if_addr), .if_spm_as_(if_as_), .if_spm_rw(if_rw), .if_spm_be(if_be),
    .if_spm_wr_data(if_wd), .if_spm_rd_data(if_rd_a), .if_spm_rdy_(if_rdy_a),
    .mem_spm_addr(mem_addr), .mem_spm_as_(mem_as_), .mem_spm_rw(mem_rw), .mem_spm_be(mem_be),
    .mem_spm_wr_data(mem_wd), .mem_spm_rd_data(mem_rd_a), .mem_spm_rdy_(mem_rdy_a));

  spm_banked #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .STARVE_MAX(0), .INIT_CLEAR(1)) dut_b (
    .clk(clk), .reset(reset_b), .init_busy(busy_b),
    .if_spm_addr(if_addr), .if_spm_as_(if_as_), .if_spm_rw(if_rw), .if_spm_be(if_be),
    .if_spm_wr_data(if_wd), .if_spm_rd_data(if_rd_b), .if_spm_rdy_(if_rdy_b),
    .mem_spm_addr(mem_addr), .mem_spm_as_(mem_as_), .mem_spm_rw(mem_rw), .mem_spm_be(mem_be),
    .mem_spm_wr_data(mem_wd), .mem_spm_rd_data(mem_rd_b), .mem_spm_rdy_(mem_rdy_b));

  spm_banked #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .STARVE_MAX(3), .INIT_CLEAR(0)) dut_c (
    .clk(clk), .reset(reset_c), .init_busy(busy_c),
    .if_spm_addr(if_addr), .if_spm_as_(if_as_), .if_spm_rw(if_rw), .if_spm_be(if_be),
    .if_spm_wr_data(if_wd), .if_spm_rd_data(if_rd_c), .if_spm_rdy_(if_rdy_c),
    .mem_spm_addr(mem_addr), .mem_spm_as_(mem_as_), .mem_spm_rw(mem_rw), .mem_spm_be(mem_be),
    .mem_spm_wr_data(mem_wd), .mem_spm_rd_data(mem_rd_c), .mem_spm_rdy_(mem_rdy_c));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [64];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    for (int i = 0; i < BEW; i++) r[i*8 +: 8] = be[i] ? d[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_as_ = 1'b1;
    mem_as_ = 1'b1;
  endtask

  task automatic drive_if(input logic [AW-1:0] a, input logic rw, input logic [BEW-1:0] be,
                          input logic [DW-1:0] d);
    if_addr = a; if_as_ = 1'b0; if_rw = rw; if_be = be; if_wd = d;
  endtask

  task automatic drive_mem(input logic [AW-1:0] a, input logic rw, input logic [BEW-1:0] be,
                           input logic [DW-1:0] d);
    mem_addr = a; mem_as_ = 1'b0; mem_rw = rw; mem_be = be; mem_wd = d;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    drive_if(6'd1, 1'b1, 4'h0, '0);
    drive_mem(6'd2, 1'b0, 4'hf, 32'h12345678);
    tick(); tick();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a: got %b want 1", busy_a); end
    checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL reset_busy_c: got %b want 0", busy_c); end
    checks++; if (if_rdy_a !== 1'b1) begin errors++; $display("FAIL reset_if_rdy: got %b want 1", if_rdy_a); end
    checks++; if (mem_rdy_a !== 1'b1) begin errors++; $display("FAIL reset_mem_rdy: got %b want 1", mem_rdy_a); end
    checks++; if (mem_rdy_c !== 1'b1) begin errors++; $display("FAIL reset_mem_rdy_c: got %b want 1", mem_rdy_c); end
    checks++; if (if_rd_a !== 32'h0) begin errors++; $display("FAIL reset_if_rd: got %h want 0", if_rd_a); end
    checks++; if (mem_rd_a !== 32'h0) begin errors++; $display("FAIL reset_mem_rd: got %h want 0", mem_rd_a); end
    idle();
  endtask

  task automatic test_init();
    int cnt, rdy_bad;
    reset_a = 1'b0;
    repeat (16) tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL init_first_done: got %b want 0", busy_a); end
    for (int a = 0; a < 64; a++) begin
      drive_mem(6'(a), 1'b0, 4'hf, $urandom | 32'h1);
      tick();
    end
    idle();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    cnt = 0; rdy_bad = 0;
    for (int i = 0; i < 40; i++) begin
      drive_if(6'($urandom_range(0, 63)), 1'b0, 4'hf, $urandom | 32'h1);
      drive_mem(6'($urandom_range(0, 63)), 1'b0, 4'hf, $urandom | 32'h1);
      #1;
      if (busy_a !== 1'b1) break;
      cnt++;
      if (if_rdy_a !== 1'b1 || mem_rdy_a !== 1'b1) rdy_bad++;
      tick();
    end
    idle();
    checks++; if (cnt != 16) begin errors++; $display("FAIL init_length: got %0d want 16", cnt); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL init_rdy_high: got %0d cycles low want 0", rdy_bad); end
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    for (int a = 0; a < 64; a++) begin
      drive_if(6'(a), 1'b1, 4'h0, '0);
      tick();
      checks++;
      if (if_rd_a !== ref_mem[a]) begin errors++; $display("FAIL init_zero[%0d]: got %h want %h", a, if_rd_a, ref_mem[a]); end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] d;
    logic [AW-1:0] addrs [16];
    drive_mem(6'h05, 1'b0, 4'hf, 32'h11223344); tick();
    drive_mem(6'h05, 1'b0, 4'b0101, 32'hAABBCCDD); tick();
    ref_mem[5] = merge(merge(ref_mem[5], 32'h11223344, 4'hf), 32'hAABBCCDD, 4'b0101);
    drive_mem(6'h05, 1'b1, 4'h0, '0);
    #1;
    checks++; if (mem_rdy_a !== 1'b0) begin errors++; $display("FAIL be_read_rdy: got %b want 0", mem_rdy_a); end
    tick();
    checks++; if (mem_rd_a !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge: got %h want 11bb33dd", mem_rd_a); end
    drive_mem(6'h05, 1'b0, 4'hf, 32'h0BADF00D); tick();
    ref_mem[5] = 32'h0BADF00D;
    checks++; if (mem_rd_a !== 32'h11BB33DD) begin errors++; $display("FAIL rd_hold_on_write: got %h want 11bb33dd", mem_rd_a); end
    d = $urandom;
    drive_mem(6'h06, 1'b0, 4'h0, d);
    #1;
    checks++; if (mem_rdy_a !== 1'b0) begin errors++; $display("FAIL be_zero_rdy: got %b want 0", mem_rdy_a); end
    tick();
    for (int i = 0; i < 16; i++) begin
      addrs[i] = 6'($urandom_range(0, 63));
      d = $urandom;
      if (i % 2 == 0) begin
        idle(); drive_mem(addrs[i], 1'b0, 4'($urandom_range(0, 15)), d);
        ref_mem[addrs[i]] = merge(ref_mem[addrs[i]], d, mem_be);
      end else begin
        idle(); drive_if(addrs[i], 1'b0, 4'($urandom_range(0, 15)), d);
        ref_mem[addrs[i]] = merge(ref_mem[addrs[i]], d, if_be);
      end
      tick();
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      drive_mem(6'(a), 1'b1, 4'h0, '0);
      tick();
      checks++;
      if (mem_rd_a !== ref_mem[a]) begin errors++; $display("FAIL be_readback[%0d]: got %h want %h", a, mem_rd_a, ref_mem[a]); end
    end
    for (int i = 0; i < 16; i++) begin
      drive_mem(addrs[i], 1'b1, 4'h0, '0);
      tick();
      checks++;
      if (mem_rd_a !== ref_mem[addrs[i]]) begin errors++; $display("FAIL be_random[%0d]: got %h want %h", addrs[i], mem_rd_a, ref_mem[addrs[i]]); end
    end
    idle();
  endtask

  task automatic test_parallel();
    logic [DW-1:0] d;
    d = $urandom | 32'h100;
    drive_mem(6'h04, 1'b0, 4'hf, d); tick();
    ref_mem[4] = d;
    d = $urandom;
    drive_if(6'h04, 1'b1, 4'h0, '0);
    drive_mem(6'h09, 1'b0, 4'hf, d);
    #1;
    checks++; if (if_rdy_a !== 1'b0) begin errors++; $display("FAIL par_if_rdy: got %b want 0", if_rdy_a); end
    checks++; if (mem_rdy_a !== 1'b0) begin errors++; $display("FAIL par_mem_rdy: got %b want 0", mem_rdy_a); end
    tick();
    idle();
    ref_mem[9] = d;
    checks++; if (if_rd_a !== ref_mem[4]) begin errors++; $display("FAIL par_if_data: got %h want %h", if_rd_a, ref_mem[4]); end
    drive_if(6'h09, 1'b1, 4'h0, '0); tick(); idle();
    checks++; if (if_rd_a !== ref_mem[9]) begin errors++; $display("FAIL par_mem_wrote: got %h want %h", if_rd_a, ref_mem[9]); end
  endtask

  task automatic test_back_to_back();
    int starve;
    logic [DW-1:0] exp_if, exp_mem, d_if, d_mem;
    logic [AW-1:0] ia, ma;
    logic i_act, m_act, irw, mrw, same_bank, ig, mg;
    logic [BEW-1:0] ibe, mbe;
    starve = 0;
    drive_if(6'd0, 1'b1, 4'h0, '0);
    drive_mem(6'd1, 1'b1, 4'h0, '0);
    tick(); idle();
    exp_if = ref_mem[0]; exp_mem = ref_mem[1];
    for (int c = 0; c < 200; c++) begin
      ia = 6'($urandom_range(0, 63)); ma = 6'($urandom_range(0, 63));
      i_act = ($urandom_range(0, 3) != 0); m_act = ($urandom_range(0, 3) != 0);
      irw = 1'($urandom_range(0, 1)); mrw = 1'($urandom_range(0, 1));
      ibe = 4'($urandom_range(0, 15)); mbe = 4'($urandom_range(0, 15));
      d_if = $urandom; d_mem = $urandom;
      idle();
      if (i_act) drive_if(ia, irw, ibe, d_if);
      if (m_act) drive_mem(ma, mrw, mbe, d_mem);
      #1;
      same_bank = i_act && m_act && ((ia % NB) == (ma % NB));
      ig = i_act && !(same_bank && starve != 3);
      mg = m_act && !(same_bank && starve == 3);
      checks++; if (if_rdy_a !== !ig) begin errors++; $display("FAIL b2b_if_rdy c%0d: got %b want %b", c, if_rdy_a, !ig); end
      checks++; if (mem_rdy_a !== !mg) begin errors++; $display("FAIL b2b_mem_rdy c%0d: got %b want %b", c, mem_rdy_a, !mg); end
      if (ig && irw) exp_if = ref_mem[ia];
      if (mg && mrw) exp_mem = ref_mem[ma];
      if (ig && !irw) ref_mem[ia] = merge(ref_mem[ia], d_if, ibe);
      if (mg && !mrw) ref_mem[ma] = merge(ref_mem[ma], d_mem, mbe);
      if (ig) starve = 0;
      else if (same_bank) starve = (starve < 3) ? starve + 1 : 3;
      tick();
      checks++; if (if_rd_a !== exp_if) begin errors++; $display("FAIL b2b_if_data c%0d: got %h want %h", c, if_rd_a, exp_if); end
      checks++; if (mem_rd_a !== exp_mem) begin errors++; $display("FAIL b2b_mem_data c%0d: got %h want %h", c, mem_rd_a, exp_mem); end
    end
    idle();
  endtask

  task automatic test_starvation();
    logic want_if;
    idle();
    drive_if(6'h08, 1'b1, 4'h0, '0); tick();
    for (int c = 0; c < 12; c++) begin
      drive_if(6'h08, 1'b1, 4'h0, '0);
      drive_mem(6'h0C, 1'b1, 4'h0, '0);
      #1;
      want_if = ((c % 4) == 3);
      checks++; if (if_rdy_a !== !want_if) begin errors++; $display("FAIL starve_if_rdy c%0d: got %b want %b", c, if_rdy_a, !want_if); end
      checks++; if (mem_rdy_a !== want_if) begin errors++; $display("FAIL starve_mem_rdy c%0d: got %b want %b", c, mem_rdy_a, want_if); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    drive_mem(6'h01, 1'b0, 4'hf, 32'hDEADBEEF); tick();
    drive_mem(6'h02, 1'b0, 4'hf, 32'hCAFEF00D); tick();
    drive_if(6'h01, 1'b1, 4'h0, '0);
    drive_mem(6'h02, 1'b1, 4'h0, '0);
    tick(); idle();
    checks++; if (if_rd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_pre_if: got %h want deadbeef", if_rd_a); end
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    repeat (7) tick();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy_row7: got %b want 1", busy_a); end
    reset_a = 1'b1;
    drive_if(6'h03, 1'b1, 4'h0, '0);
    drive_mem(6'h04, 1'b0, 4'hf, 32'h55555555);
    #1;
    checks++; if (if_rdy_a !== 1'b1 || mem_rdy_a !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy: got %b%b want 11", if_rdy_a, mem_rdy_a); end
    tick();
    idle();
    reset_a = 1'b0;
    checks++; if (if_rd_a !== 32'h0) begin errors++; $display("FAIL mid_if_rd_zero: got %h want 0", if_rd_a); end
    checks++; if (mem_rd_a !== 32'h0) begin errors++; $display("FAIL mid_mem_rd_zero: got %h want 0", mem_rd_a); end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy_a !== 1'b1) break;
      cnt++;
      tick();
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL mid_init_length: got %0d want 16", cnt); end
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    for (int a = 0; a < 64; a++) begin
      drive_mem(6'(a), 1'b1, 4'h0, '0);
      tick();
      checks++;
      if (mem_rd_a !== ref_mem[a]) begin errors++; $display("FAIL mid_zero[%0d]: got %h want %h", a, mem_rd_a, ref_mem[a]); end
    end
    idle();
    reset_a = 1'b1;
  endtask

  task automatic test_starve_off();
    reset_b = 1'b0;
    repeat (16) tick();
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL off_busy: got %b want 0", busy_b); end
    for (int c = 0; c < 12; c++) begin
      drive_if(6'h08, 1'b1, 4'h0, '0);
      drive_mem(6'h0C, 1'b1, 4'h0, '0);
      #1;
      checks++; if (if_rdy_b !== 1'b1) begin errors++; $display("FAIL off_if_rdy c%0d: got %b want 1", c, if_rdy_b); end
      checks++; if (mem_rdy_b !== 1'b0) begin errors++; $display("FAIL off_mem_rdy c%0d: got %b want 0", c, mem_rdy_b); end
      tick();
    end
    idle();
    reset_b = 1'b1;
  endtask

  task automatic test_no_init();
    logic [DW-1:0] cval [8];
    logic [AW-1:0] caddr [8];
    for (int i = 0; i < 8; i++) begin
      caddr[i] = 6'(3 + i * 7);
      cval[i] = $urandom | 32'h1;
    end
    reset_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_mem(caddr[i], 1'b0, 4'hf, cval[i]);
      #1;
      checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL noinit_busy i%0d: got %b want 0", i, busy_c); end
      checks++; if (mem_rdy_c !== 1'b0) begin errors++; $display("FAIL noinit_wr_rdy i%0d: got %b want 0", i, mem_rdy_c); end
      tick();
    end
    idle();
    reset_c = 1'b1;
    tick();
    checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL noinit_reset_busy: got %b want 0", busy_c); end
    reset_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_if(caddr[i], 1'b1, 4'h0, '0);
      #1;
      checks++; if (if_rdy_c !== 1'b0) begin errors++; $display("FAIL noinit_rd_rdy i%0d: got %b want 0", i, if_rdy_c); end
      tick();
      checks++; if (if_rd_c !== cval[i]) begin errors++; $display("FAIL noinit_data[%0d]: got %h want %h", caddr[i], if_rd_c, cval[i]); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    if_addr = '0; mem_addr = '0; if_rw = 1'b1; mem_rw = 1'b1;
    if_be = '0; mem_be = '0; if_wd = '0; mem_wd = '0;
    idle();
    test_reset();
    test_init();
    test_byte_enable();
    test_parallel();
    test_back_to_back();
    test_starvation();
    test_reset_mid_init();
    test_starve_off();
    test_no_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spm_banked.md
Name: spm_banked

Overview:
- Parametrised, banked, dual-port scratchpad memory for the CPU core.
- Port A serves the IF stage and port B serves the MEM stage.
- Storage is NUM_BANKS single-port RAM banks, interleaved on the low word-address bits. Byte-enable writes are supported.
- Same-bank collisions are arbitrated: MEM has priority, with a starvation guard for IF.
- An optional zero-fill FSM runs after reset.

Parameters:
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 12: word-address width per port.
- NUM_BANKS, 4: bank count; power of 2, 1..2^ADDR_W.
- STARVE_MAX, 3: consecutive IF conflict losses before IF is forced to win; 0 disables the override (MEM always wins).
- INIT_CLEAR, 1: 1 enables zero-fill after reset; 0 skips it.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- init_busy  out  1  high while the zero-fill runs.
- if_spm_addr  in  ADDR_W  IF word address.
- if_spm_as_  in  1  IF address strobe, active-low.
- if_spm_rw  in  1  IF read(1)/write(0) (`READ/`WRITE).
- if_spm_be  in  DATA_W/8  IF byte enables; used on writes only.
- if_spm_wr_data  in  DATA_W  IF write data.
- if_spm_rd_data  out  DATA_W  IF read data.
- if_spm_rdy_  out  1  IF request accepted this cycle, active-low.
- mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_be, mem_spm_wr_data, mem_spm_rd_data, mem_spm_rdy_: same widths and meaning as the IF ports, for the MEM port.

Behaviour:
- Bank select and row:
  - bank = addr[log2(NUM_BANKS)-1:0]
  - row = addr[ADDR_W-1:log2(NUM_BANKS)]
  - NUM_BANKS=1 means a single bank with row = addr.
- Reset (reset=1 at a clk edge):
  - rd_data on both ports <= 0.
  - Starvation counter <= 0.
  - FSM <= INIT if INIT_CLEAR=1, else RUN.
  - Memory contents are not cleared by reset itself.
  - While reset is high, both rdy_ are 1 and init_busy = INIT_CLEAR.
- FSM states:
  - INIT:
    - A row counter runs 0..2^ADDR_W/NUM_BANKS-1. Every bank writes all-zero at that row, one row per cycle.
    - init_busy=1; both rdy_=1; requests are ignored, not queued.
    - At the last row, transition to RUN next cycle.
    - Total duration is 2^ADDR_W/NUM_BANKS cycles.
    - Reset mid-INIT restarts the counter at 0.
  - RUN: init_busy=0; normal operation.
- Grant (combinational, same cycle):
  - A port with as_=1 is idle and its rdy_=1.
  - Requests to different banks: both are granted.
  - Both requests to the same bank:
    - MEM is granted by default.
    - IF is granted instead when STARVE_MAX>0 and starve_cnt==STARVE_MAX.
    - The loser sees rdy_=1 and must hold its request; the core stalls.
- Starvation counter:
  - Increments when an IF request loses a conflict.
  - Clears when IF is granted.
  - Holds otherwise.
  - Saturates at STARVE_MAX.
- Granted write:
  - At the clk edge, for each byte i with be[i]=1, bank[row] byte i <= wr_data byte i.
  - rd_data is unchanged by writes.
- Granted read:
  - rd_data <= bank[row] at the clk edge, i.e. valid the cycle after rdy_ goes low.
  - rd_data holds until the next granted read on that port.
- A read granted in the same cycle as a write to the same row on the other port is impossible: a same-bank pair is always serialised.
- A port's write followed by that same port's read of the same row next cycle returns the new data.
- be=0 on a granted write is accepted (rdy_=0) and changes nothing.
- Reset asserted in any cycle overrides all grants: no write occurs in that cycle.

Test Plan:
1. ADDR_W=6, NUM_BANKS=4, INIT_CLEAR=1; preload nonzero via backdoor, release reset -> init_busy=1 for exactly 16 cycles, rdy_=1 throughout; afterwards reads of addresses 0..63 return 0.
2. MEM write addr 0x005, be=4'b0101, data 0xAABBCCDD over an old value of 0x11223344 -> subsequent read returns 0x11BB33DD one cycle after rdy_ goes low.
3. IF reads addr 0x004 while MEM writes addr 0x009 (banks 0 and 1) -> both rdy_=0 in the same cycle; the IF read data is valid next cycle.
4. IF and MEM request addrs 0x008 and 0x00C (both bank 0) continuously with STARVE_MAX=3 -> MEM wins 3 cycles, IF wins the 4th, and the pattern repeats; with STARVE_MAX=0, IF never wins.
5. Assert reset at INIT row 7, hold for 1 cycle -> INIT restarts at row 0 and lasts the full 16 cycles; rd_data=0 on both ports.
6. INIT_CLEAR=0 -> init_busy=0 and rdy_ available in the first cycle after reset; a read before any write returns the backdoor-preloaded content.
